// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI transmit master.
// Counter widths are derived from the parameters so a single source sizes both counters.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    function automatic int half_cnt_w(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

    function automatic int toggle_cnt_w(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/spi_tick.sv
// Half-period timebase: a down-counter that pulses tick every CLK_DIV clk cycles.
// A restart reloads the count so the next tick lands exactly CLK_DIV cycles later.
module spi_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int              CW     = half_cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI transmit master with chip-select burst hold and a word-aligned D/C line.
//   state | meaning
//   IDLE  | rdy high, waiting for en; cs_n held low between burst words
//   LEAD  | cs_n low, sclk parked at CPOL for one half-period before the first toggle
//   SHIFT | 2*WIDTH sclk toggles one half-period apart, sdo follows CPHA
//   TRAIL | sclk back at CPOL, one half-period hold before done
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic             dc_in,
    input  logic             last,
    output logic             rdy,
    output logic             done,
    output logic             sclk,
    output logic             sdo,
    output logic             cs_n,
    output logic             dc
);

    localparam int            TW       = toggle_cnt_w(WIDTH);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * WIDTH);
    localparam logic [TW-1:0] TOG_ONE  = TW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [TW-1:0]    tog_q, tog_d, tog_nx;
    logic             last_q, last_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tick;
    logic             restart;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign tog_nx  = tog_q + 1'b1;
    assign restart = accept || (state_d != state_q);

    spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            tog_q   <= '0;
            last_q  <= 1'b0;
            sclk_q  <= CPOL;
            sdo_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tog_q   <= tog_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
        end
    end

    // The shift register always holds the bits still to be presented; sdo is loaded
    // from its head and the register shifted in the same cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        tog_d   = tog_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        cs_n_d  = cs_n_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    accept  = 1'b1;
                    shreg_d = data;
                    dc_d    = dc_in;
                    last_d  = last;
                    tog_d   = '0;
                    if (cs_n_q) begin
                        state_d = LEAD;
                        cs_n_d  = 1'b0;
                        if (!CPHA) begin
                            sdo_d   = first_bit(data);
                            shreg_d = shift_word(data);
                        end
                    end else begin
                        // Burst word: chip-select is already settled, so the first toggle
                        // is issued straight away.
                        state_d = SHIFT;
                        sclk_d  = ~sclk_q;
                        tog_d   = TOG_ONE;
                        sdo_d   = first_bit(data);
                        shreg_d = shift_word(data);
                    end
                end
            end

            LEAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = ~sclk_q;
                    tog_d   = TOG_ONE;
                    if (CPHA) begin
                        sdo_d   = first_bit(shreg_q);
                        shreg_d = shift_word(shreg_q);
                    end
                end
            end

            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    tog_d  = tog_nx;
                    if (tog_nx == TOG_LAST) begin
                        state_d = TRAIL;
                    end
                    if (CPHA ? tog_nx[0] : (!tog_nx[0] && (tog_nx != TOG_LAST))) begin
                        sdo_d   = first_bit(shreg_q);
                        shreg_d = shift_word(shreg_q);
                    end
                end
            end

            TRAIL: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sdo_d   = 1'b0;
                    if (last_q) begin
                        cs_n_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdy  = (state_q == IDLE);
    assign done = done_q;
    assign sclk = sclk_q;
    assign sdo  = sdo_q;
    assign cs_n = cs_n_q;
    assign dc   = dc_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four configurations checked every cycle against a closed-form
// timing model, plus a passive slave and hand-computed word/timing expectations.
module tb_spi_master;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_n, en, dc_in, last;
    logic [N-1:0] rdy, done, sclk, sdo, cs_n, dc;
    logic [7:0]   data0, data1, data2;
    logic [15:0]  data3;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Configuration of each instance: 0 mode0/MSB, 1 mode3/MSB, 2 mode3/LSB, 3 W16 D1 mode0.
    function automatic int p_w(input int i);
        return (i == 3) ? 16 : 8;
    endfunction
    function automatic int p_d(input int i);
        return (i == 3) ? 1 : 4;
    endfunction
    function automatic logic p_cpol(input int i);
        return (i == 1 || i == 2);
    endfunction
    function automatic logic p_cpha(input int i);
        return (i == 1 || i == 2);
    endfunction
    function automatic logic p_msb(input int i);
        return (i != 2);
    endfunction

    spi_master #(.WIDTH(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
        .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .data(data0), .dc_in(dc_in[0]), .last(last[0]),
        .rdy(rdy[0]), .done(done[0]), .sclk(sclk[0]), .sdo(sdo[0]), .cs_n(cs_n[0]), .dc(dc[0]));
    spi_master #(.WIDTH(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m3 (
        .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .data(data1), .dc_in(dc_in[1]), .last(last[1]),
        .rdy(rdy[1]), .done(done[1]), .sclk(sclk[1]), .sdo(sdo[1]), .cs_n(cs_n[1]), .dc(dc[1]));
    spi_master #(.WIDTH(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m3l (
        .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .data(data2), .dc_in(dc_in[2]), .last(last[2]),
        .rdy(rdy[2]), .done(done[2]), .sclk(sclk[2]), .sdo(sdo[2]), .cs_n(cs_n[2]), .dc(dc[2]));
    spi_master #(.WIDTH(16), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n[3]), .en(en[3]), .data(data3), .dc_in(dc_in[3]), .last(last[3]),
        .rdy(rdy[3]), .done(done[3]), .sclk(sclk[3]), .sdo(sdo[3]), .cs_n(cs_n[3]), .dc(dc[3]));

    function automatic logic [15:0] cur_data(input int i);
        case (i)
            0:       return {8'h00, data0};
            1:       return {8'h00, data1};
            2:       return {8'h00, data2};
            default: return data3;
        endcase
    endfunction

    task automatic set_data(input int i, input logic [15:0] w);
        case (i)
            0:       data0 = w[7:0];
            1:       data1 = w[7:0];
            2:       data2 = w[7:0];
            default: data3 = w;
        endcase
    endtask

    task automatic check_bit(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A word accepted at edge k with lead L (D, or 0 when cs_n was already low) toggles
    // sclk for the n-th time at edge k+L+(n-1)*D and completes at edge k+L+2*W*D.
    logic        m_busy [N];
    int          m_k    [N];
    int          m_l    [N];
    int          m_done_at [N];
    logic [15:0] m_word [N];
    logic        m_last [N];
    logic        m_cs   [N];
    logic        m_dc   [N];
    int          acc_cnt [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0; m_k[i] = 0; m_l[i] = 0; m_done_at[i] = -1;
            m_word[i] = '0; m_last[i] = 1'b0; m_cs[i] = 1'b1; m_dc[i] = 1'b0; acc_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst_n[i] && rdy[i] && en[i]) acc_cnt[i]++;
            if (!rst_n[i]) begin
                m_busy[i] = 1'b0; m_cs[i] = 1'b1; m_dc[i] = 1'b0; m_done_at[i] = -1;
            end else if (m_busy[i]) begin
                if (cyc == m_k[i] + m_l[i] + 2 * p_w(i) * p_d(i)) begin
                    m_busy[i]    = 1'b0;
                    m_done_at[i] = cyc;
                    if (m_last[i]) m_cs[i] = 1'b1;
                end
            end else if (en[i]) begin
                m_busy[i] = 1'b1;
                m_k[i]    = cyc;
                m_l[i]    = m_cs[i] ? p_d(i) : 0;
                m_word[i] = cur_data(i);
                m_last[i] = last[i];
                m_dc[i]   = dc_in[i];
                m_cs[i]   = 1'b0;
            end
        end
    end

    function automatic logic exp_bit(input int i, input int idx);
        return p_msb(i) ? m_word[i][p_w(i) - 1 - idx] : m_word[i][idx];
    endfunction

    always @(negedge clk) begin
        int   t, n, idx;
        logic e_sclk, e_sdo, e_cs, e_rdy, e_done;
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    t = cyc - m_k[i];
                    n = (t < m_l[i]) ? 0 : (t - m_l[i]) / p_d(i) + 1;
                    if (n > 2 * p_w(i)) n = 2 * p_w(i);
                    e_sclk = (n % 2 == 1) ? ~p_cpol(i) : p_cpol(i);
                    if (!p_cpha(i)) begin
                        idx   = (n / 2 > p_w(i) - 1) ? p_w(i) - 1 : n / 2;
                        e_sdo = exp_bit(i, idx);
                    end else if (n == 0) begin
                        e_sdo = 1'b0;
                    end else begin
                        idx   = ((n - 1) / 2 > p_w(i) - 1) ? p_w(i) - 1 : (n - 1) / 2;
                        e_sdo = exp_bit(i, idx);
                    end
                    e_cs = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
                end else begin
                    e_sclk = p_cpol(i); e_sdo = 1'b0; e_cs = m_cs[i]; e_rdy = 1'b1;
                    e_done = (cyc == m_done_at[i]);
                end
                check_bit("sclk", i, sclk[i], e_sclk);
                check_bit("sdo",  i, sdo[i],  e_sdo);
                check_bit("cs_n", i, cs_n[i], e_cs);
                check_bit("rdy",  i, rdy[i],  e_rdy);
                check_bit("done", i, done[i], e_done);
                check_bit("dc",   i, dc[i],   m_dc[i]);
            end
        end
    end

    // ---------------- passive slave (samples sdo on rising sclk) ----------------
    logic [N-1:0] sclk_prev, sdo_prev;
    logic [15:0]  rx  [N];
    int           rx_n [N];
    logic [15:0]  got [N];
    int           got_n [N];
    int           bad_sdo [N];
    logic         cs_watch = 1'b0;
    int           cs_hi = 0;

    initial begin
        sclk_prev = '0; sdo_prev = '0;
        for (int i = 0; i < N; i++) begin
            rx[i] = '0; rx_n[i] = 0; got[i] = '0; got_n[i] = 0; bad_sdo[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n[i]) begin
                rx[i] = '0; rx_n[i] = 0;
            end else begin
                if (!cs_n[i] && sclk[i] && !sclk_prev[i]) begin
                    rx[i] = {rx[i][14:0], sdo[i]};
                    rx_n[i]++;
                end
                if (!cs_n[i] && !done[i] && (sdo[i] !== sdo_prev[i]) && !(!sclk[i] && sclk_prev[i]))
                    bad_sdo[i]++;
                if (done[i]) begin
                    got[i] = rx[i]; got_n[i] = rx_n[i]; rx[i] = '0; rx_n[i] = 0;
                end
            end
        end
        if (cs_watch && cs_n[0] && !done[0]) cs_hi++;
        sclk_prev = sclk;
        sdo_prev  = sdo;
    end

    // ---------------- stimulus ----------------
    task automatic send(input int i, input logic [15:0] w, input logic d, input logic l, output int k);
        int g = 0;
        while (!rdy[i] && g < 500) begin @(negedge clk); g++; end
        check_val("rdy_wait", int'(rdy[i]), 1);
        set_data(i, w); dc_in[i] = d; last[i] = l; en[i] = 1'b1;
        @(negedge clk);
        k = cyc;
        en[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int d, output logic cs_at);
        int g = 0;
        while (!done[i] && g < 3000) begin @(negedge clk); g++; end
        check_val("done_wait", int'(done[i]), 1);
        d = cyc;
        cs_at = cs_n[i];
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, k2, d, d2, g, tg, a0;
        logic cs_at, pv;
        rst_n = '0; en = '0; dc_in = '0; last = '0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        repeat (3) @(negedge clk);
        check_val("reset_rdy",  int'(rdy[0]),  1);
        check_val("reset_cs_n", int'(cs_n[0]), 1);
        check_val("reset_sclk_cpol1", int'(sclk[1]), 1);
        check_val("reset_sdo",  int'(sdo[0]),  0);
        rst_n = '1;
        @(negedge clk);

        // Mode 0, 8'hA5, last=1 (edge offsets are one less than visible-cycle offsets)
        send(0, 16'h00A5, 1'b1, 1'b1, k);
        check_val("m0_cs_low_at_accept", int'(cs_n[0]), 0);
        check_val("m0_dc_at_accept",     int'(dc[0]),   1);
        g = 0;
        while (!sclk[0] && g < 100) begin @(negedge clk); g++; end
        check_val("m0_cs_to_first_rise", cyc - k, 4);
        wait_done(0, d, cs_at);
        check_val("m0_done_latency", d - k + 1, 69);
        check_val("m0_cs_high_at_done", int'(cs_at), 1);
        check_val("m0_rx_word", int'(got[0][7:0]), 8'hA5);
        check_val("m0_rx_bits", got_n[0], 8);

        // Mode 3, 8'h3C
        check_val("m3_sclk_idle_high", int'(sclk[1]), 1);
        send(1, 16'h003C, 1'b0, 1'b1, k);
        wait_done(1, d, cs_at);
        check_val("m3_done_latency", d - k + 1, 69);
        check_val("m3_rx_word", int'(got[1][7:0]), 8'h3C);
        check_val("m3_sdo_only_on_fall", bad_sdo[1], 0);

        // Mode 3, LSB first, 8'h01: first sampled bit 1, rest 0
        send(2, 16'h0001, 1'b0, 1'b1, k);
        wait_done(2, d, cs_at);
        check_val("lsb_rx_word", int'(got[2][7:0]), 8'h80);
        check_val("lsb_rx_bits", got_n[2], 8);
        check_val("lsb_sdo_only_on_fall", bad_sdo[2], 0);

        // Burst: 8'hAE (dc=0,last=0) then 8'h7E (dc=1,last=1)
        send(0, 16'h00AE, 1'b0, 1'b0, k);
        cs_watch = 1'b1;
        check_val("burst_dc_word1", int'(dc[0]), 0);
        wait_done(0, d, cs_at);
        check_val("burst_cs_held_at_done", int'(cs_at), 0);
        check_val("burst_rx_word1", int'(got[0][7:0]), 8'hAE);
        send(0, 16'h007E, 1'b1, 1'b1, k2);
        check_val("burst_dc_word2", int'(dc[0]), 1);
        wait_done(0, d2, cs_at);
        cs_watch = 1'b0;
        check_val("burst_done_latency", d2 - k2 + 1, 65);
        check_val("burst_cs_never_high", cs_hi, 0);
        check_val("burst_rx_word2", int'(got[0][7:0]), 8'h7E);
        check_val("burst_cs_released", int'(cs_at), 1);

        // en held high, data wiggling during the word
        a0 = acc_cnt[0];
        set_data(0, 16'h00C3); dc_in[0] = 1'b1; last[0] = 1'b1; en[0] = 1'b1;
        @(negedge clk);
        g = 0;
        while (!done[0] && g < 2000) begin
            set_data(0, {8'h00, 8'(cyc) ^ 8'h5A});
            @(negedge clk);
            g++;
        end
        check_val("hold_done_seen", int'(done[0]), 1);
        set_data(0, 16'h0096);
        @(negedge clk);
        check_val("hold_rx_word1", int'(got[0][7:0]), 8'hC3);
        en[0] = 1'b0;
        wait_done(0, d, cs_at);
        check_val("hold_rx_word2", int'(got[0][7:0]), 8'h96);
        check_val("hold_acceptances", acc_cnt[0] - a0, 2);

        // Reset at toggle 7, then a fresh word
        send(0, 16'h005A, 1'b0, 1'b1, k);
        tg = 0; g = 0; pv = sclk[0];
        while (tg < 7 && g < 500) begin
            @(negedge clk);
            if (sclk[0] !== pv) begin tg++; pv = sclk[0]; end
            g++;
        end
        check_val("rst_toggle_count", tg, 7);
        rst_n[0] = 1'b0;
        set_data(0, 16'h0069); dc_in[0] = 1'b0; last[0] = 1'b1; en[0] = 1'b1;
        @(negedge clk);
        check_val("rst_cs_n", int'(cs_n[0]), 1);
        check_val("rst_sclk", int'(sclk[0]), 0);
        check_val("rst_sdo",  int'(sdo[0]),  0);
        check_val("rst_rdy",  int'(rdy[0]),  1);
        check_val("rst_done", int'(done[0]), 0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        wait_done(0, d, cs_at);
        check_val("rst_rx_word", int'(got[0][7:0]), 8'h69);
        check_val("rst_rx_bits", got_n[0], 8);

        // WIDTH=16, CLK_DIV=1
        send(3, 16'hBEEF, 1'b1, 1'b1, k);
        wait_done(3, d, cs_at);
        check_val("w16_done_latency", d - k + 1, 34);
        check_val("w16_rx_word", int'(got[3]), 16'hBEEF);
        check_val("w16_rx_bits", got_n[3], 16);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
